// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver feeding a small command parser that turns 'W'/'R' packets
// into single-cycle write/read requests for a memory controller.
module uart_cmd_rx #(
  parameter int FREQ         = 54_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd,
  input  logic        busy,
  output logic        rd,
  output logic        wr,
  output logic [24:0] addr,
  output logic [15:0] din,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        frame_err,
  output logic        overrun
);
  localparam int CPB       = FREQ / BAUD;
  localparam int CW        = $clog2(CPB);
  localparam int TO_CYCLES = TIMEOUT_BITS * CPB;
  localparam int TW        = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {P_IDLE, P_ADDR, P_DATA, P_ISSUE} p_state_e;

  logic            rxd_s1_q, rxd_s2_q, rxd_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_byte_q;
  logic            rx_valid_q, frame_err_q;
  logic            byte_done, stop_bad;

  p_state_e        p_state_q, p_state_d;
  logic            op_q;
  logic [1:0]      bcnt_q;
  logic [16:0]     addr_sh_q;
  logic [7:0]      din_hi_q;
  logic [TW-1:0]   to_cnt_q;
  logic [24:0]     addr_q;
  logic [15:0]     din_q;
  logic            issue_entry;

  // ---------------- receiver ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      rxd_prev_q  <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rxd_s1_q    <= uart_rxd;
      rxd_s2_q    <= rxd_s1_q;
      rxd_prev_q  <= rxd_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= byte_done ? shift_q : rx_byte_q;
      rx_valid_q  <= byte_done;
      frame_err_q <= stop_bad;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          bit_idx_d  = '0;
          rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d  = '0;
          shift_d   = {rxd_s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: begin
        if (rx_cnt_q == BIT_LAST) rx_state_d = RX_IDLE;
        else                      rx_cnt_d   = rx_cnt_q + 1'b1;
      end
    endcase
  end

  always_comb begin
    byte_done = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST) && rxd_s2_q;
    stop_bad  = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST) && !rxd_s2_q;
  end

  // ---------------- parser ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) p_state_q <= P_IDLE;
    else       p_state_q <= p_state_d;
  end

  // A packet already waiting in P_ISSUE is complete, so later line errors do not cancel it.
  always_comb begin
    p_state_d = p_state_q;
    case (p_state_q)
      P_IDLE: begin
        if (rx_valid_q && (rx_byte_q == 8'h57 || rx_byte_q == 8'h52)) p_state_d = P_ADDR;
      end
      P_ADDR: begin
        if (frame_err_q)                           p_state_d = P_IDLE;
        else if (rx_valid_q && bcnt_q == 2'd2)     p_state_d = op_q ? P_DATA : P_ISSUE;
        else if (!rx_valid_q && to_cnt_q == TO_LAST) p_state_d = P_IDLE;
      end
      P_DATA: begin
        if (frame_err_q)                           p_state_d = P_IDLE;
        else if (rx_valid_q && bcnt_q == 2'd1)     p_state_d = P_ISSUE;
        else if (!rx_valid_q && to_cnt_q == TO_LAST) p_state_d = P_IDLE;
      end
      default: begin
        if (!busy) p_state_d = P_IDLE;
      end
    endcase
  end

  always_comb begin
    rd      = (p_state_q == P_ISSUE) && !busy && !op_q;
    wr      = (p_state_q == P_ISSUE) && !busy && op_q;
    overrun = (p_state_q == P_ISSUE) && rx_valid_q;
  end

  assign issue_entry = (p_state_d == P_ISSUE) && (p_state_q != P_ISSUE);

  // Only bit 0 of the first address byte is kept; it lands just above the two low bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= 1'b0;
      bcnt_q    <= '0;
      addr_sh_q <= '0;
      din_hi_q  <= '0;
      to_cnt_q  <= '0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      if ((p_state_q == P_ADDR || p_state_q == P_DATA) && !rx_valid_q) to_cnt_q <= to_cnt_q + 1'b1;
      else                                                              to_cnt_q <= '0;
      if (rx_valid_q) begin
        case (p_state_q)
          P_IDLE: begin
            op_q   <= (rx_byte_q == 8'h57);
            bcnt_q <= '0;
          end
          P_ADDR: begin
            bcnt_q <= (bcnt_q == 2'd2) ? 2'd0 : bcnt_q + 2'd1;
            case (bcnt_q)
              2'd0:    addr_sh_q       <= {rx_byte_q[0], 16'h0000};
              2'd1:    addr_sh_q[15:8] <= rx_byte_q;
              default: addr_sh_q[7:0]  <= rx_byte_q;
            endcase
          end
          P_DATA: begin
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd0) din_hi_q <= rx_byte_q;
          end
          default: ;
        endcase
      end
      if (issue_entry) begin
        addr_q <= op_q ? {8'h00, addr_sh_q} : {8'h00, addr_sh_q[16:8], rx_byte_q};
        if (op_q) din_q <= {din_hi_q, rx_byte_q};
      end
    end
  end

  assign addr          = addr_q;
  assign din           = din_q;
  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_valid_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: serial packets in, request pulses and registers checked.
module tb_uart_cmd_rx;
  localparam int FREQ = 1_600_000;
  localparam int BAUD = 100_000;
  localparam int CPB  = FREQ / BAUD;
  localparam int TOB  = 32;

  logic        clk = 1'b0;
  logic        reset, uart_rxd, busy;
  logic        rd, wr, rx_byte_valid, frame_err, overrun;
  logic [24:0] addr;
  logic [15:0] din;
  logic [7:0]  rx_byte;

  always #5 clk = ~clk;

  uart_cmd_rx #(.FREQ(FREQ), .BAUD(BAUD), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .busy(busy),
    .rd(rd), .wr(wr), .addr(addr), .din(din),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .frame_err(frame_err), .overrun(overrun)
  );

  int total = 0, bad = 0;
  int rd_n = 0, wr_n = 0, val_n = 0, fe_n = 0, ov_n = 0, clash_n = 0;
  int b_rd, b_wr, b_val, b_fe, b_ov;
  logic [24:0] wr_addr_seen = '0, rd_addr_seen = '0;
  logic [15:0] wr_din_seen = '0;

  always @(negedge clk) begin
    if (rd) begin rd_n++; rd_addr_seen = addr; end
    if (wr) begin wr_n++; wr_addr_seen = addr; wr_din_seen = din; end
    if (rx_byte_valid) val_n++;
    if (frame_err) fe_n++;
    if (overrun) ov_n++;
    if ((rd && wr) || (frame_err && rx_byte_valid)) clash_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_rd = rd_n; b_wr = wr_n; b_val = val_n; b_fe = fe_n; b_ov = ov_n;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      idle(CPB);
    end
    uart_rxd = stop_bit;
    idle(CPB);
    uart_rxd = 1'b1;
  endtask

  task automatic send4(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0, 1'b1); send_byte(b1, 1'b1); send_byte(b2, 1'b1); send_byte(b3, 1'b1);
  endtask

  initial begin
    reset = 1'b1; uart_rxd = 1'b1; busy = 1'b0;
    idle(3);
    check("rst_rd", 32'(rd), 0);
    check("rst_wr", 32'(wr), 0);
    check("rst_valid", 32'(rx_byte_valid), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_din", 32'(din), 0);
    check("rst_rx_byte", 32'(rx_byte), 0);
    reset = 1'b0;
    idle(2 * CPB);

    // Write command
    snap();
    send4(8'h57, 8'h00, 8'h12, 8'h34);
    send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
    idle(20);
    check("w_wr_count", wr_n - b_wr, 1);
    check("w_rd_count", rd_n - b_rd, 0);
    check("w_valid_count", val_n - b_val, 6);
    check("w_addr_at_pulse", 32'(wr_addr_seen), 32'h001234);
    check("w_din_at_pulse", 32'(wr_din_seen), 32'hABCD);
    check("w_addr_hold", 32'(addr), 32'h001234);
    check("w_rx_byte", 32'(rx_byte), 32'hCD);

    // Read with top address bit, then the 0xFF first-byte variant
    snap();
    send4(8'h52, 8'h01, 8'hFF, 8'hFF);
    idle(20);
    check("r1_rd_count", rd_n - b_rd, 1);
    check("r1_wr_count", wr_n - b_wr, 0);
    check("r1_addr", 32'(rd_addr_seen), 32'h1FFFF);
    check("r1_din_kept", 32'(din), 32'hABCD);
    snap();
    send4(8'h52, 8'hFF, 8'hFF, 8'hFF);
    idle(20);
    check("r2_rd_count", rd_n - b_rd, 1);
    check("r2_addr", 32'(rd_addr_seen), 32'h1FFFF);

    // Busy hold with an overrun byte while held
    busy = 1'b1;
    snap();
    send4(8'h52, 8'h00, 8'h00, 8'h05);
    send_byte(8'h41, 1'b1);
    idle(1000);
    check("hold_rd_count", rd_n - b_rd, 0);
    check("hold_overrun", ov_n - b_ov, 1);
    check("hold_valid_count", val_n - b_val, 5);
    check("hold_rx_byte", 32'(rx_byte), 32'h41);
    @(posedge clk);
    #1 busy = 1'b0;
    @(negedge clk);
    check("release_rd_high", 32'(rd), 1);
    check("release_addr", 32'(addr), 32'h5);
    @(negedge clk);
    check("release_rd_low", 32'(rd), 0);
    check("release_rd_count", rd_n - b_rd, 1);
    check("release_wr_count", wr_n - b_wr, 0);

    // Framing error
    snap();
    send_byte(8'h3C, 1'b0);
    idle(2 * CPB);
    check("fe_count", fe_n - b_fe, 1);
    check("fe_valid_count", val_n - b_val, 0);
    check("fe_rx_byte_kept", 32'(rx_byte), 32'h41);

    // Inter-byte timeout, then a clean read
    snap();
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1);
    idle(40 * CPB);
    check("to_no_request", (rd_n - b_rd) + (wr_n - b_wr), 0);
    send4(8'h52, 8'h00, 8'h00, 8'h77);
    idle(20);
    check("to_rd_count", rd_n - b_rd, 1);
    check("to_wr_count", wr_n - b_wr, 0);
    check("to_addr", 32'(rd_addr_seen), 32'h77);

    // Reset in the middle of the second address byte
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1);
    uart_rxd = 1'b0; idle(CPB);
    uart_rxd = 1'b0; idle(CPB);
    uart_rxd = 1'b1; idle(CPB);
    uart_rxd = 1'b0; idle(CPB / 2);
    reset = 1'b1; uart_rxd = 1'b1;
    idle(3);
    check("mid_rst_addr", 32'(addr), 0);
    check("mid_rst_din", 32'(din), 0);
    check("mid_rst_rx_byte", 32'(rx_byte), 0);
    snap();
    reset = 1'b0;
    idle(2 * CPB);
    check("post_rst_quiet", val_n - b_val, 0);
    send4(8'h57, 8'h00, 8'h0A, 8'hBC);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    idle(20);
    check("post_rst_wr_count", wr_n - b_wr, 1);
    check("post_rst_rd_count", rd_n - b_rd, 0);
    check("post_rst_addr", 32'(wr_addr_seen), 32'h000ABC);
    check("post_rst_din", 32'(wr_din_seen), 32'h1234);
    check("post_rst_valid_count", val_n - b_val, 6);

    // 0.3-bit low glitch
    snap();
    uart_rxd = 1'b0; idle(5);
    uart_rxd = 1'b1; idle(3 * CPB);
    check("glitch_valid", val_n - b_val, 0);
    check("glitch_frame_err", fe_n - b_fe, 0);

    check("no_pulse_clash", clash_n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
